// File: rtl/ray_generator_pkg.sv
// ray_pkg: shared types and default widths for the ray generator slice.
//   ray_state_e : frame sequencer states (IDLE / ISSUE / DRAIN)
//   vec3_t      : packed signed 3-component vector, x in the low bits
//   RAY_*_WIDTH : default widths used by the top and the ray interface
package ray_pkg;

  localparam int unsigned RAY_POSITION_WIDTH = 16;
  localparam int unsigned RAY_ADDRESS_WIDTH  = 32;
  localparam int unsigned RAY_COUNT_WIDTH    = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } ray_state_e;

  // Component order matches the flat 3*W ports: x = [W-1:0], y = [2W-1:W], z = [3W-1:2W].
  typedef struct packed {
    logic signed [RAY_POSITION_WIDTH-1:0] z;
    logic signed [RAY_POSITION_WIDTH-1:0] y;
    logic signed [RAY_POSITION_WIDTH-1:0] x;
  } vec3_t;

endpackage

// File: rtl/ray_generator_if.sv
// ray_generator_if: ray issue channel from the generator to the tracer cores.
//   rayValid   : ray fields valid (master -> slave)
//   rayReady   : core accepts the ray (slave -> master)
//   rayQ       : ray origin, 3 x POSITION_WIDTH unsigned
//   rayDir     : ray direction, 3 x POSITION_WIDTH signed
//   rayAddress : destination pixel address
//   rayLast    : final pixel of the frame
interface ray_generator_if
  import ray_pkg::*;
#(
  parameter int unsigned POSITION_WIDTH = RAY_POSITION_WIDTH,
  parameter int unsigned ADDRESS_WIDTH  = RAY_ADDRESS_WIDTH
);

  logic                        rayValid;
  logic                        rayReady;
  logic [3*POSITION_WIDTH-1:0] rayQ;
  logic [3*POSITION_WIDTH-1:0] rayDir;
  logic [ADDRESS_WIDTH-1:0]    rayAddress;
  logic                        rayLast;

  modport master (
    output rayValid,
    input  rayReady,
    output rayQ,
    output rayDir,
    output rayAddress,
    output rayLast
  );

  modport slave (
    input  rayValid,
    output rayReady,
    input  rayQ,
    input  rayDir,
    input  rayAddress,
    input  rayLast
  );

endinterface

// File: rtl/ray_generator_vec3_accumulator.sv
// vec3_accumulator: one 3-component register with load and add-step.
//   i_clk, i_rst_n : clock, synchronous active-low reset (clears the value)
//   i_load         : replace the value with i_load_value (wins over i_add)
//   i_load_value   : 3 x W load vector
//   i_add          : add i_add_value lane-wise (two's complement wrap)
//   i_add_value    : 3 x W step vector
//   o_value        : current register value
//   o_sum          : o_value + i_add_value, lane-wise, combinational
module vec3_accumulator #(
  parameter int unsigned W = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_load,
  input  logic [3*W-1:0] i_load_value,
  input  logic           i_add,
  input  logic [3*W-1:0] i_add_value,
  output logic [3*W-1:0] o_value,
  output logic [3*W-1:0] o_sum
);

  logic [3*W-1:0] r_value;
  logic [3*W-1:0] w_sum;

  // Lanes are summed separately so a carry never crosses into the next component.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_sum[i*W +: W] = r_value[i*W +: W] + i_add_value[i*W +: W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_value;
    end else if (i_add) begin
      r_value <= w_sum;
    end
  end

  assign o_value = r_value;
  assign o_sum   = w_sum;

endmodule

// File: rtl/ray_generator.sv
// ray_generator: walks a frame in raster order and issues one ray per pixel.
//   clock, reset  : system clock, synchronous active-low reset
//   start, flush  : frame start pulse, abort pulse (flush wins)
//   frameAddress  : address of pixel (0,0)
//   cameraQ/V/X/Y : origin, pixel (0,0) direction, column step, row step
//   width, height : frame size in pixels; a zero dimension ignores start
//   ready, busy   : idle / frame in progress (issuing or draining)
//   ray           : ray issue channel (ray_generator_if.master)
//   doneStrobe    : one pixel completed by a core
//   frameCycles   : cycles spent busy in the current/last frame
//                   (present only when RAY_GEN_PERF_EN is defined)
module ray_generator
  import ray_pkg::*;
#(
  parameter int unsigned POSITION_WIDTH = RAY_POSITION_WIDTH,
  parameter int unsigned ADDRESS_WIDTH  = RAY_ADDRESS_WIDTH,
  parameter int unsigned COUNT_WIDTH    = RAY_COUNT_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        flush,
  input  logic [ADDRESS_WIDTH-1:0]    frameAddress,
  input  logic [3*POSITION_WIDTH-1:0] cameraQ,
  input  logic [3*POSITION_WIDTH-1:0] cameraV,
  input  logic [3*POSITION_WIDTH-1:0] cameraX,
  input  logic [3*POSITION_WIDTH-1:0] cameraY,
  input  logic [11:0]                 width,
  input  logic [11:0]                 height,
  output logic                        ready,
  output logic                        busy,
  ray_generator_if.master             ray,
  input  logic                        doneStrobe
`ifdef RAY_GEN_PERF_EN
  ,
  output logic [31:0]                 frameCycles
`endif
);

  ray_state_e r_state;
  ray_state_e w_next;

  logic [3*POSITION_WIDTH-1:0] r_q;
  logic [3*POSITION_WIDTH-1:0] r_x;
  logic [3*POSITION_WIDTH-1:0] r_y;
  logic [11:0]                 r_width;
  logic [11:0]                 r_height;
  logic [11:0]                 r_px;
  logic [11:0]                 r_py;
  logic [ADDRESS_WIDTH-1:0]    r_addr;
  logic [COUNT_WIDTH-1:0]      r_outstanding;

  logic                        w_accept;
  logic                        w_hs;
  logic                        w_row_end;
  logic                        w_last;
  logic                        w_valid;
  logic [3*POSITION_WIDTH-1:0] w_dir;
  logic [3*POSITION_WIDTH-1:0] w_dir_sum;
  logic [3*POSITION_WIDTH-1:0] w_row_dir;
  logic [3*POSITION_WIDTH-1:0] w_row_sum;

  assign w_valid   = (r_state == ISSUE);
  assign w_accept  = start && !flush && (r_state == IDLE) && (width != '0) && (height != '0);
  assign w_hs      = w_valid && ray.rayReady && !flush;
  assign w_row_end = (r_px == r_width - 12'd1);
  assign w_last    = w_row_end && (r_py == r_height - 12'd1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b1;
    unique case (r_state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (w_accept) w_next = ISSUE;
      end
      ISSUE: begin
        if (w_hs && w_last) w_next = DRAIN;
      end
      DRAIN: begin
        if (r_outstanding == '0) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_width  <= '0;
      r_height <= '0;
    end else if (w_accept) begin
      r_q      <= cameraQ;
      r_x      <= cameraX;
      r_y      <= cameraY;
      r_width  <= width;
      r_height <= height;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_px   <= '0;
      r_py   <= '0;
      r_addr <= '0;
    end else if (w_accept) begin
      r_px   <= '0;
      r_py   <= '0;
      r_addr <= frameAddress;
    end else if (w_hs) begin
      if (w_row_end) begin
        r_px <= '0;
        r_py <= r_py + 12'd1;
      end else begin
        r_px <= r_px + 12'd1;
      end
      r_addr <= r_addr + ADDRESS_WIDTH'(1);
    end
  end

  // A handshake and a completion in the same cycle cancel out.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      r_outstanding <= '0;
    end else if (w_hs && !doneStrobe) begin
      r_outstanding <= r_outstanding + COUNT_WIDTH'(1);
    end else if (!w_hs && doneStrobe && (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - COUNT_WIDTH'(1);
    end
  end

  // rowDir exposes rowDir+Y so the pixel direction can reload the next row start
  // in the same cycle rowDir itself steps.
  vec3_accumulator #(.W(POSITION_WIDTH)) u_row_dir (
    .i_clk        (clock),
    .i_rst_n      (reset),
    .i_load       (w_accept),
    .i_load_value (cameraV),
    .i_add        (w_hs && w_row_end),
    .i_add_value  (r_y),
    .o_value      (w_row_dir),
    .o_sum        (w_row_sum)
  );

  vec3_accumulator #(.W(POSITION_WIDTH)) u_dir (
    .i_clk        (clock),
    .i_rst_n      (reset),
    .i_load       (w_accept || (w_hs && w_row_end)),
    .i_load_value (w_accept ? cameraV : w_row_sum),
    .i_add        (w_hs && !w_row_end),
    .i_add_value  (r_x),
    .o_value      (w_dir),
    .o_sum        (w_dir_sum)
  );

  assign ray.rayValid   = w_valid;
  assign ray.rayQ       = r_q;
  assign ray.rayDir     = w_dir;
  assign ray.rayAddress = r_addr;
  assign ray.rayLast    = w_valid && w_last;

`ifdef RAY_GEN_PERF_EN
  logic [31:0] r_frame_cycles;

  always_ff @(posedge clock) begin
    if (!reset || flush || w_accept) begin
      r_frame_cycles <= '0;
    end else if (r_state != IDLE) begin
      r_frame_cycles <= r_frame_cycles + 32'd1;
    end
  end

  assign frameCycles = r_frame_cycles;
`endif

  // The direction accumulator's own sum is not needed; the rowDir sum feeds it instead.
  logic w_unused;
  assign w_unused = ^{w_dir_sum, w_row_dir};

endmodule

// File: tb/tb_ray_generator.sv
module tb_ray_generator;

  logic        clock;
  logic        reset;
  logic        start;
  logic        flush;
  logic [31:0] frameAddress;
  logic [47:0] cameraQ, cameraV, cameraX, cameraY;
  logic [11:0] width, height;
  logic        ready, busy;
  logic        doneStrobe;
`ifdef RAY_GEN_PERF_EN
  logic [31:0] frameCycles;
`endif

  int tests = 0;
  int fails = 0;

  ray_generator_if #(.POSITION_WIDTH(16), .ADDRESS_WIDTH(32)) rif ();

  ray_generator #(
    .POSITION_WIDTH (16),
    .ADDRESS_WIDTH  (32),
    .COUNT_WIDTH    (24)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .flush        (flush),
    .frameAddress (frameAddress),
    .cameraQ      (cameraQ),
    .cameraV      (cameraV),
    .cameraX      (cameraX),
    .cameraY      (cameraY),
    .width        (width),
    .height       (height),
    .ready        (ready),
    .busy         (busy),
    .ray          (rif.master),
    .doneStrobe   (doneStrobe)
`ifdef RAY_GEN_PERF_EN
    ,
    .frameCycles  (frameCycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [47:0] v3(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    return {z, y, x};
  endfunction

  task automatic pulse_done(input int n);
    for (int j = 0; j < n; j++) begin
      doneStrobe = 1'b1;
      @(posedge clock); #1;
    end
    doneStrobe = 1'b0;
  endtask

  // Returns in the first ISSUE cycle (start accepted at the preceding edge).
  task automatic start_frame(input logic [11:0] w, input logic [11:0] h, input logic [47:0] q,
                             input logic [47:0] v, input logic [47:0] x, input logic [47:0] y,
                             input logic [31:0] a);
    @(posedge clock); #1;
    width = w; height = h; cameraQ = q; cameraV = v; cameraX = x; cameraY = y;
    frameAddress = a; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++;
    if ({ready, busy, rif.rayValid, rif.rayLast} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_status: ready/busy/valid/last=%b want 1000", {ready, busy, rif.rayValid, rif.rayLast});
    end
    tests++;
    if ({rif.rayQ, rif.rayDir, rif.rayAddress} !== 128'd0) begin
      fails++;
      $display("FAIL reset_outputs: q=%h dir=%h addr=%h want all 0", rif.rayQ, rif.rayDir, rif.rayAddress);
    end
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_basic;
    logic [47:0] ed;
    logic [31:0] ea;
    rif.rayReady = 1'b1;
    start_frame(12'd3, 12'd2, v3(1, 2, 3), v3(0, 0, 100), v3(1, 0, 0), v3(0, 1, 0), 32'h1000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      ed = v3(16'(i % 3), 16'(i / 3), 16'd100);
      ea = 32'h1000 + 32'(i);
      tests++;
      if ({rif.rayValid, rif.rayDir, rif.rayAddress, rif.rayLast, rif.rayQ} !==
          {1'b1, ed, ea, (i == 5), v3(1, 2, 3)}) begin
        fails++;
        $display("FAIL basic_ray%0d: valid=%b dir=%h addr=%h last=%b q=%h want 1 %h %h %b %h",
                 i, rif.rayValid, rif.rayDir, rif.rayAddress, rif.rayLast, rif.rayQ,
                 ed, ea, (i == 5), v3(1, 2, 3));
      end
      @(posedge clock); #1;
      // A start and new camera inputs mid-frame must not disturb the frame.
      if (i == 2) begin
        cameraV = v3(7, 7, 7); frameAddress = 32'hDEAD0000; start = 1'b1;
      end
      if (i == 3) start = 1'b0;
    end
    @(negedge clock);
    tests++;
    if ({rif.rayValid, busy, ready} !== 3'b010) begin
      fails++;
      $display("FAIL basic_drain_entry: valid/busy/ready=%b want 010", {rif.rayValid, busy, ready});
    end
    pulse_done(5);
    @(negedge clock);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy_5done: busy=%b want 1", busy);
    end
    pulse_done(1);
    @(negedge clock);
    tests++;
    if ({busy, ready} !== 2'b10) begin
      fails++;
      $display("FAIL basic_drain_last: busy/ready=%b want 10", {busy, ready});
    end
    @(posedge clock);
    @(negedge clock);
    tests++;
    if ({busy, ready} !== 2'b01) begin
      fails++;
      $display("FAIL basic_idle: busy/ready=%b want 01", {busy, ready});
    end
  endtask

  task automatic test_backpressure;
    int          k;
    logic [47:0] ed;
    logic [31:0] ea;
    k = 0;
    rif.rayReady = 1'b0;
    start_frame(12'd2, 12'd2, v3(4, 5, 6), v3(10, 20, 30), v3(1, 0, 0), v3(0, 2, 0), 32'h2000);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clock); #1;
      rif.rayReady = cyc[0];
      @(negedge clock);
      if (rif.rayValid) begin
        tests++;
        if (k < 4) begin
          ed = v3(16'(10 + k % 2), 16'(20 + 2 * (k / 2)), 16'd30);
          ea = 32'h2000 + 32'(k);
          if ({rif.rayDir, rif.rayAddress, rif.rayLast, rif.rayQ} !== {ed, ea, (k == 3), v3(4, 5, 6)}) begin
            fails++;
            $display("FAIL bp_ray%0d_cyc%0d: dir=%h addr=%h last=%b q=%h want %h %h %b %h",
                     k, cyc, rif.rayDir, rif.rayAddress, rif.rayLast, rif.rayQ,
                     ed, ea, (k == 3), v3(4, 5, 6));
          end
        end else begin
          fails++;
          $display("FAIL bp_extra_ray: valid=1 after %0d handshakes want 0", k);
        end
        if (rif.rayReady) k++;
      end
    end
    tests++;
    if (k !== 4) begin
      fails++;
      $display("FAIL bp_handshakes: got %0d want 4", k);
    end
    @(posedge clock); #1;
    rif.rayReady = 1'b0;
    pulse_done(4);
    @(posedge clock);
    @(negedge clock);
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_idle: ready=%b want 1", ready);
    end
  endtask

  task automatic test_wrap;
    rif.rayReady = 1'b1;
    start_frame(12'd2, 12'd1, v3(0, 0, 0), v3(16'h7FFF, 0, 0), v3(1, 0, 0), v3(0, 0, 0), 32'h4000);
    @(negedge clock);
    tests++;
    if ({rif.rayDir, rif.rayLast} !== {v3(16'h7FFF, 0, 0), 1'b0}) begin
      fails++;
      $display("FAIL wrap_ray0: dir=%h last=%b want %h 0", rif.rayDir, rif.rayLast, v3(16'h7FFF, 0, 0));
    end
    @(posedge clock);
    @(negedge clock);
    tests++;
    if ({rif.rayDir, rif.rayAddress, rif.rayLast} !== {v3(16'h8000, 0, 0), 32'h4001, 1'b1}) begin
      fails++;
      $display("FAIL wrap_ray1: dir=%h addr=%h last=%b want %h 00004001 1",
               rif.rayDir, rif.rayAddress, rif.rayLast, v3(16'h8000, 0, 0));
    end
    @(posedge clock); #1;
    pulse_done(2);
    @(posedge clock);
    @(negedge clock);
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL wrap_idle: ready=%b want 1", ready);
    end
  endtask

  task automatic test_zero_size;
    rif.rayReady = 1'b1;
    start_frame(12'd0, 12'd5, v3(1, 1, 1), v3(1, 1, 1), v3(1, 1, 1), v3(1, 1, 1), 32'h9000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      tests++;
      if ({busy, rif.rayValid, ready} !== 3'b001) begin
        fails++;
        $display("FAIL zero_size_cyc%0d: busy/valid/ready=%b want 001", c, {busy, rif.rayValid, ready});
      end
    end
  endtask

  task automatic test_flush;
    rif.rayReady = 1'b1;
    start_frame(12'd4, 12'd4, v3(0, 0, 0), v3(0, 0, 1), v3(1, 0, 0), v3(0, 1, 0), 32'h5000);
    @(posedge clock);
    @(posedge clock); #1;
    flush = 1'b1;
    @(negedge clock);
    tests++;
    if ({rif.rayAddress, rif.rayDir} !== {32'h5002, v3(2, 0, 1)}) begin
      fails++;
      $display("FAIL flush_pre: addr=%h dir=%h want 00005002 %h", rif.rayAddress, rif.rayDir, v3(2, 0, 1));
    end
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    tests++;
    if ({rif.rayValid, ready, busy} !== 3'b010) begin
      fails++;
      $display("FAIL flush_idle: valid/ready/busy=%b want 010", {rif.rayValid, ready, busy});
    end
    start_frame(12'd1, 12'd1, v3(0, 0, 0), v3(5, 6, 7), v3(1, 0, 0), v3(0, 1, 0), 32'h3000);
    @(negedge clock);
    tests++;
    if ({rif.rayValid, rif.rayLast, rif.rayDir, rif.rayAddress} !== {1'b1, 1'b1, v3(5, 6, 7), 32'h3000}) begin
      fails++;
      $display("FAIL flush_1x1_ray: valid=%b last=%b dir=%h addr=%h want 1 1 %h 00003000",
               rif.rayValid, rif.rayLast, rif.rayDir, rif.rayAddress, v3(5, 6, 7));
    end
    @(posedge clock); #1;
    @(negedge clock);
    tests++;
    if ({rif.rayValid, busy} !== 2'b01) begin
      fails++;
      $display("FAIL flush_1x1_single: valid/busy=%b want 01", {rif.rayValid, busy});
    end
    pulse_done(1);
    @(posedge clock);
    @(negedge clock);
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_1x1_idle: ready=%b want 1 (stale outstanding count)", ready);
    end
  endtask

  task automatic test_simultaneous_done;
    rif.rayReady = 1'b1;
    start_frame(12'd3, 12'd1, v3(0, 0, 0), v3(0, 0, 0), v3(1, 0, 0), v3(0, 0, 0), 32'h6000);
    @(posedge clock); #1;
    doneStrobe = 1'b1;
    @(posedge clock); #1;
    doneStrobe = 1'b0;
    @(posedge clock); #1;
    // Three handshakes, one coinciding with a completion: two pixels outstanding.
    pulse_done(1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL simul_outstanding: busy=%b want 1 with one pixel outstanding", busy);
    end
    pulse_done(1);
    @(posedge clock);
    @(negedge clock);
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL simul_drained: ready=%b want 1", ready);
    end
    pulse_done(2);
    @(negedge clock);
    tests++;
    if ({ready, busy} !== 2'b10) begin
      fails++;
      $display("FAIL idle_done: ready/busy=%b want 10", {ready, busy});
    end
    start_frame(12'd1, 12'd1, v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 0), 32'h7000);
    @(posedge clock); #1;
    pulse_done(1);
    @(posedge clock);
    @(negedge clock);
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL no_underflow: ready=%b want 1", ready);
    end
  endtask

  task automatic test_reset_midframe;
    rif.rayReady = 1'b1;
    start_frame(12'd4, 12'd4, v3(9, 9, 9), v3(3, 3, 3), v3(1, 0, 0), v3(0, 1, 0), 32'h8000);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({ready, rif.rayValid, rif.rayQ, rif.rayDir, rif.rayAddress} !== {1'b1, 1'b0, 128'd0}) begin
      fails++;
      $display("FAIL reset_mid: ready=%b valid=%b q=%h dir=%h addr=%h want 1 0 and zeros",
               ready, rif.rayValid, rif.rayQ, rif.rayDir, rif.rayAddress);
    end
    start_frame(12'd1, 12'd1, v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 0), 32'hA000);
    @(posedge clock); #1;
    pulse_done(1);
    @(posedge clock);
    @(negedge clock);
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_count: ready=%b want 1", ready);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; doneStrobe = 1'b0;
    frameAddress = '0; cameraQ = '0; cameraV = '0; cameraX = '0; cameraY = '0;
    width = '0; height = '0;
    rif.rayReady = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_zero_size;
    test_flush;
    test_simultaneous_done;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
